// File: rtl/decode_regread_pkg.sv
// decode_regread_pkg: opcodes, instruction field positions and scoreboard helpers
// shared by the decode/register-read stage.
package decode_regread_pkg;
   localparam int REG_COUNT = 16;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_LD  = 4'd7;
   localparam logic [3:0] OP_DOT = 4'd14;
   localparam logic [3:0] OP_NOP = 4'd15;
   localparam logic [15:0] NOP_INS = 16'hF000;
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RA_HI = 11;
   localparam int RA_LO = 8;
   localparam int RB_HI = 7;
   localparam int RB_LO = 4;
   localparam int RT_HI = 3;
   localparam int RT_LO = 0;

   typedef struct packed {
      logic       v;
      logic [3:0] tag;
   } sb_slot_t;

   // Every writer reads ra; unknown opcodes decode as nop.
   function automatic logic writes_rt(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LD, OP_DOT};
   endfunction

   function automatic logic reads_rb(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DOT};
   endfunction

   function automatic logic sb_busy(input logic [3:0] r, input sb_slot_t a, input sb_slot_t b);
      return r != 4'd0 && ((a.v && a.tag == r) || (b.v && b.tag == r));
   endfunction
endpackage

// File: rtl/decode_regread_if.sv
// decode_regread_if: fetch handshake, writeback port and execute-side outputs
// of the decode/register-read stage.
interface decode_regread_if;
   logic [15:0] in_ins;
   logic        in_valid;
   logic        in_ready;
   logic        wb_en;
   logic [3:0]  wb_rt;
   logic [15:0] wb_data;
   logic [15:0] fr_ins;
   logic        fr_valid;
   logic [15:0] fr_operand_1;
   logic [15:0] fr_operand_2;
   logic [15:0] mem_raddr;
   logic        mem_ren;

   modport master (
      output in_ins, in_valid, wb_en, wb_rt, wb_data,
      input  in_ready, fr_ins, fr_valid, fr_operand_1, fr_operand_2, mem_raddr, mem_ren
   );
   modport slave (
      input  in_ins, in_valid, wb_en, wb_rt, wb_data,
      output in_ready, fr_ins, fr_valid, fr_operand_1, fr_operand_2, mem_raddr, mem_ren
   );
endinterface

// File: rtl/decode_regread_regfile16.sv
// regfile16: 16x16 register file, two async read ports with writeback
// write-through, one sync write port, r0 hardwired to zero.
module regfile16
   import decode_regread_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_we,
   input  logic [3:0]  i_waddr,
   input  logic [15:0] i_wdata,
   input  logic [3:0]  i_raddr_1,
   input  logic [3:0]  i_raddr_2,
   output logic [15:0] o_rdata_1,
   output logic [15:0] o_rdata_2
);
   logic [15:0] r_regs [REG_COUNT];

   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      else if (i_we && i_waddr != 4'd0) r_regs[i_waddr] <= i_wdata;

   always_comb begin
      o_rdata_1 = (i_raddr_1 == 4'd0) ? '0 : (i_we && i_waddr == i_raddr_1) ? i_wdata : r_regs[i_raddr_1];
      o_rdata_2 = (i_raddr_2 == 4'd0) ? '0 : (i_we && i_waddr == i_raddr_2) ? i_wdata : r_regs[i_raddr_2];
   end
endmodule

// File: rtl/decode_regread.sv
// decode_regread: decodes the fetched instruction, reads operands and stalls
// on RAW hazards against writers still in execute 1 / execute 2.
module decode_regread
   import decode_regread_pkg::*;
(
   input logic clk,
   input logic rst,
   decode_regread_if.slave bus
);
   logic [3:0]  w_op, w_ra, w_rb, w_rt;
   logic [15:0] w_rd_1, w_rd_2;
   logic        w_hazard, w_issue, w_ld;
   logic [15:0] r_fr_ins, r_op_1, r_op_2, r_mem_raddr;
   logic        r_fr_valid, r_mem_ren;
   sb_slot_t    r_sb_x, r_sb_x2;

   assign w_op = bus.in_ins[OPC_HI:OPC_LO];
   assign w_ra = bus.in_ins[RA_HI:RA_LO];
   assign w_rb = bus.in_ins[RB_HI:RB_LO];
   assign w_rt = bus.in_ins[RT_HI:RT_LO];
   assign w_ld = w_op == OP_LD;
   assign w_hazard = bus.in_valid && ((writes_rt(w_op) && sb_busy(w_ra, r_sb_x, r_sb_x2)) ||
                                      (reads_rb(w_op) && sb_busy(w_rb, r_sb_x, r_sb_x2)));
   assign w_issue = bus.in_valid && !w_hazard;

   regfile16 u_rf (
      .clk       (clk),
      .rst       (rst),
      .i_we      (bus.wb_en),
      .i_waddr   (bus.wb_rt),
      .i_wdata   (bus.wb_data),
      .i_raddr_1 (w_ra),
      .i_raddr_2 (w_rb),
      .o_rdata_1 (w_rd_1),
      .o_rdata_2 (w_rd_2)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_fr_ins    <= NOP_INS;
         r_fr_valid  <= 1'b0;
         r_op_1      <= '0;
         r_op_2      <= '0;
         r_mem_raddr <= '0;
         r_mem_ren   <= 1'b0;
         r_sb_x      <= '0;
         r_sb_x2     <= '0;
      end else begin
         r_fr_ins    <= w_issue ? bus.in_ins : NOP_INS;
         r_fr_valid  <= w_issue;
         r_op_1      <= w_issue ? w_rd_1 : '0;
         r_op_2      <= w_issue ? w_rd_2 : '0;
         r_mem_raddr <= (w_issue && w_ld) ? w_rd_1 : '0;
         r_mem_ren   <= w_issue && w_ld;
         r_sb_x2     <= r_sb_x;
         r_sb_x      <= '{v: w_issue && writes_rt(w_op), tag: w_rt};
      end

   assign bus.in_ready     = !w_hazard;
   assign bus.fr_ins       = r_fr_ins;
   assign bus.fr_valid     = r_fr_valid;
   assign bus.fr_operand_1 = r_op_1;
   assign bus.fr_operand_2 = r_op_2;
   assign bus.mem_raddr    = r_mem_raddr;
   assign bus.mem_ren      = r_mem_ren;
endmodule

// File: tb/tb_decode_regread.sv
// tb_decode_regread: directed vectors; the driver queues each cycle's expected
// stage output and an independent monitor compares it one edge later.
module tb_decode_regread;
   import decode_regread_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_regread_if bus();
   decode_regread dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int          id;
      logic [15:0] ins;
      logic        v;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [15:0] raddr;
      logic        ren;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int n_pass = 0;
   int n_total = 0;
   int vec = 0;

   task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("fr_ins", e.id, bus.fr_ins, e.ins);
         chk("fr_valid", e.id, 16'(bus.fr_valid), 16'(e.v));
         chk("fr_operand_1", e.id, bus.fr_operand_1, e.op1);
         chk("fr_operand_2", e.id, bus.fr_operand_2, e.op2);
         chk("mem_raddr", e.id, bus.mem_raddr, e.raddr);
         chk("mem_ren", e.id, 16'(bus.mem_ren), 16'(e.ren));
      end
   end

   task automatic drive(input logic [15:0] ins, input logic v, input logic we, input logic [3:0] wrt,
                        input logic [15:0] wd, input logic rdy);
      bus.in_ins = ins;
      bus.in_valid = v;
      bus.wb_en = we;
      bus.wb_rt = wrt;
      bus.wb_data = wd;
      vec++;
      #1;
      chk("in_ready", vec, 16'(bus.in_ready), 16'(rdy));
   endtask

   task automatic step(input logic [15:0] ins, input logic v, input logic we, input logic [3:0] wrt,
                       input logic [15:0] wd, input logic rdy, input logic [15:0] eins, input logic ev,
                       input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] era, input logic eren);
      drive(ins, v, we, wrt, wd, rdy);
      q.push_back('{vec, eins, ev, e1, e2, era, eren});
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_outputs(input int id);
      chk("rst_fr_ins", id, bus.fr_ins, 16'hF000);
      chk("rst_fr_valid", id, 16'(bus.fr_valid), 16'd0);
      chk("rst_operand_1", id, bus.fr_operand_1, 16'd0);
      chk("rst_operand_2", id, bus.fr_operand_2, 16'd0);
      chk("rst_mem_raddr", id, bus.mem_raddr, 16'd0);
      chk("rst_mem_ren", id, 16'(bus.mem_ren), 16'd0);
      chk("rst_in_ready", id, 16'(bus.in_ready), 16'd1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_ins = 16'hF000;
      bus.in_valid = 1'b0;
      bus.wb_en = 1'b0;
      bus.wb_rt = 4'd0;
      bus.wb_data = 16'd0;
      repeat (2) @(posedge clk);
      #2;
      chk_reset_outputs(0);
      rst = 1'b0;
      // preload r1=5, r2=7, r4=0x20 through the writeback port
      step(16'hF000, 0, 1, 4'd1, 16'd5,    1, 16'hF000, 0, 0, 0, 0, 0);
      step(16'hF000, 0, 1, 4'd2, 16'd7,    1, 16'hF000, 0, 0, 0, 0, 0);
      step(16'hF000, 0, 1, 4'd4, 16'h0020, 1, 16'hF000, 0, 0, 0, 0, 0);
      step(16'h0123, 1, 0, 4'd0, 16'd0,    1, 16'h0123, 1, 16'd5, 16'd7, 0, 0);
      // sub reading r3 right behind its writer: two bubbles, then wb supplies r3
      step(16'h1340, 1, 0, 4'd0, 16'd0,    0, 16'hF000, 0, 0, 0, 0, 0);
      step(16'h1340, 1, 0, 4'd0, 16'd0,    0, 16'hF000, 0, 0, 0, 0, 0);
      step(16'h1340, 1, 1, 4'd3, 16'h000C, 1, 16'h1340, 1, 16'h000C, 16'h0020, 0, 0);
      step(16'h0006, 1, 0, 4'd0, 16'd0,    1, 16'h0006, 1, 0, 0, 0, 0);
      step(16'h7405, 1, 0, 4'd0, 16'd0,    1, 16'h7405, 1, 16'h0020, 0, 16'h0020, 1);
      step(16'h2125, 1, 0, 4'd0, 16'd0,    1, 16'h2125, 1, 16'd5, 16'd7, 0, 0);
      step(16'h3607, 1, 1, 4'd6, 16'hBEEF, 1, 16'h3607, 1, 16'hBEEF, 0, 0, 0);
      step(16'h0000, 1, 1, 4'd0, 16'h1234, 1, 16'h0000, 1, 0, 0, 0, 0);
      step(16'h0005, 1, 0, 4'd0, 16'd0,    1, 16'h0005, 1, 0, 0, 0, 0);
      step(16'h5123, 1, 0, 4'd0, 16'd0,    1, 16'h5123, 1, 16'd5, 16'd7, 0, 0);
      // r5 writer now sits in execute 2 only: a single bubble
      step(16'h1510, 1, 0, 4'd0, 16'd0,    0, 16'hF000, 0, 0, 0, 0, 0);
      step(16'h1510, 1, 1, 4'd5, 16'd9,    1, 16'h1510, 1, 16'd9, 16'd5, 0, 0);
      step(16'h0123, 1, 0, 4'd0, 16'd0,    1, 16'h0123, 1, 16'd5, 16'd7, 0, 0);
      // reset pulse in the middle of a stall
      drive(16'h1340, 1, 0, 4'd0, 16'd0, 0);
      rst = 1'b1;
      #1;
      chk_reset_outputs(vec);
      @(posedge clk);
      #2;
      rst = 1'b0;
      step(16'h1340, 1, 0, 4'd0, 16'd0,    1, 16'h1340, 1, 0, 0, 0, 0);
      step(16'hF000, 0, 0, 4'd0, 16'd0,    1, 16'hF000, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      chk("queue_drained", vec, 16'(q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/decode_regread.md
DECODE_REGREAD -- requirements
Module: decode_regread

Interface
REQ-001 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 rst  input  1  asynchronous reset, active-high.
REQ-003 in_ins  input  16  instruction from fetch; opcode [15:12], ra [11:8], rb [7:4], rt [3:0].
REQ-004 in_valid  input  1  in_ins holds a real instruction this cycle.
REQ-005 in_ready  output  1  stage accepts in_ins this cycle; combinational, low during hazard stall.
REQ-006 wb_en  input  1  writeback enable from the writeback stage.
REQ-007 wb_rt  input  4  writeback destination register.
REQ-008 wb_data  input  16  writeback value.
REQ-009 fr_ins  output  16  registered instruction to execute stage; 16'hF000 when bubble.
REQ-010 fr_valid  output  1  fr_ins is a real instruction.
REQ-011 fr_operand_1  output  16  registered value of reg[ra].
REQ-012 fr_operand_2  output  16  registered value of reg[rb].
REQ-013 mem_raddr  output  16  data-memory read address, registered; equals reg[ra] for ld.
REQ-014 mem_ren  output  1  data-memory read strobe, registered; high only for valid ld.

Function
REQ-015 Opcodes: 0 add, 1 sub, 2 mul, 3 div, 7 ld, 14 dot, 15 nop; all other opcodes are decoded as nop (no write, no read strobe).
REQ-016 Writers: opcodes 0,1,2,3,7,14 write rt; sources: ld reads ra only, arithmetic/dot read ra and rb.
REQ-017 Register file: 16 x 16 bits, r0 reads as 0, writes to r0 are discarded.
REQ-018 Write: reg[wb_rt] <= wb_data on rising edge when wb_en.
REQ-019 Write-through: a read of register N in the same cycle as wb_en with wb_rt == N (N != 0) returns wb_data.
REQ-020 Scoreboard: two slots, sb_x and sb_x2 (valid bit + 4-bit tag), tracking writers in execute 1 and execute 2; each cycle sb_x2 <= sb_x, sb_x <= {writes-rt, rt} of the instruction issued (bubble/nop: invalid).
REQ-021 Hazard: in_valid and any used source (nonzero) equals a valid sb_x or sb_x2 tag -> hazard = 1.
REQ-022 in_ready = !hazard; with in_valid & hazard, stage issues a bubble (fr_valid 0, fr_ins 16'hF000, mem_ren 0) and upstream holds in_ins.
REQ-023 Issue: in_valid & in_ready -> next cycle fr_ins = in_ins, fr_valid = 1, operands per REQ-019; latency one cycle.
REQ-024 in_valid low -> bubble issued, in_ready high.
REQ-025 Maximum stall: two cycles per dependency; the stall releases when the tag has shifted out of sb_x2 and the writeback write-through of REQ-019 supplies the value.
REQ-026 ld: mem_raddr = reg[ra] (write-through applied), mem_ren = 1 in the same cycle as fr_valid; non-ld: mem_raddr holds 0.
REQ-027 rt is never treated as a source; WAW hazards need no stall (in-order pipe).

Reset
REQ-028 rst high -> fr_ins 16'hF000, fr_valid 0, fr_operand_1/2 0, mem_raddr 0, mem_ren 0, both scoreboard slots invalid, all registers 0; in_ready high.
REQ-029 rst asserted mid-stall clears the stall immediately; the held instruction is reissued only after rst deasserts and upstream presents it again.

Structure
REQ-030 Shared package: opcode constants (OP_ADD..OP_NOP), NOP_INS 16'hF000, field-position constants, register count 16.
REQ-031 One sub-module, regfile16 (2 async read ports with write-through, 1 sync write port, r0 zero); scoreboard and hazard logic stay in decode_regread.

Verification
REQ-032 Reset, then in_ins 16'h0123 (add r3=r1+r2) with r1=5, r2=7 preloaded via wb -> next cycle fr_valid 1, fr_operand_1 5, fr_operand_2 7.
REQ-033 add r3 then back-to-back 16'h1340 (sub reading r3) -> in_ready low two cycles, two bubbles 16'hF000, then issue with r3 value supplied by wb_data write-through.
REQ-034 ld 16'h7405 with r4=16'h0020 -> mem_ren 1, mem_raddr 16'h0020 coincident with fr_valid; next non-ld -> mem_ren 0, mem_raddr 0.
REQ-035 wb_en, wb_rt 6, wb_data 16'hBEEF same cycle as in_ins reading r6 -> fr_operand_1 16'hBEEF; wb to r0 then read r0 -> 0.
REQ-036 Instruction writing r0 followed by reader of r0 -> no stall; rst pulse during a stall -> all outputs at reset values, in_ready high.
